// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Arbitrates two requesters onto one external ALU. Each accepted operation
// runs through a three-cycle IDLE -> EXEC -> DONE sequence:
//   IDLE : combinational grant; the accept edge captures the winner's operands
//   EXEC : the ALU is driven purely from the operand registers
//   DONE : result/flags are registered; done of the captured requester is high
// Arbitration is round-robin. Priority passes to the other requester on every
// accept.
//
// Optional feature (compile-time macro):
//   ALU_ARB_LOCK_EN  - priority locking. Accepting with lockN=1 makes N the
//                      lock owner. The owner wins every arbitration it takes
//                      part in. The owner accepting with lockN=0 releases
//                      ownership. Without the macro, lock0/lock1 are ignored.
//
// Parameters:
//   RR_INIT          - requester (0/1) that holds priority after reset
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, op0/1, a0/1,     requester interface (request, opcode, operands,
//   b0/1, s0/1, lock0/1      set-flags, lock request)
//   gnt0/1                   accept strobe (request accepted when reqN & gntN)
//   done0/1                  result valid for requester N (one cycle)
//   result, nzcv             captured result and flag register {N,Z,C,V}
//   alu_op, alu_in1,         drive the shared ALU
//   alu_in2, alu_carry
//   alu_out, alu_n/z/c/v     ALU result and flags
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic        s0,
  input  logic        s1,
  input  logic        lock0,
  input  logic        lock1,

  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic [3:0]  nzcv,

  output logic [3:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_carry,
  input  logic [31:0] alu_out,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Round-robin pointer: index of the requester that wins a tie.
  logic        prio;

  // Operand registers: everything the in-flight operation needs, captured at
  // the accept edge so later requester activity cannot disturb it.
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        s_q;
  logic        id_q;

  logic [31:0] result_q;
  logic [3:0]  nzcv_q;

  // Winner when both requesters are active.
  logic        tie_winner;
  logic        accept;
  logic        accept_id;

  // -------------------------------------------------------------------------
  // Tie-break selection
  // -------------------------------------------------------------------------
`ifdef ALU_ARB_LOCK_EN
  logic lock_valid;
  logic lock_id;
  logic accept_lock;

  // tie_winner is only consulted when both request, so a valid owner is
  // always among the requesters here; a non-requesting owner never blocks.
  assign tie_winner  = lock_valid ? lock_id : prio;
  assign accept_lock = accept_id ? lock1 : lock0;
`else
  logic unused_lock;

  assign tie_winner  = prio;
  assign unused_lock = lock0 ^ lock1;
`endif

  // -------------------------------------------------------------------------
  // Grant: combinational, only in IDLE, never while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/case leaves it unassigned (which would infer a latch).
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (req0 && req1) begin
        gnt0 = ~tie_winner;
        gnt1 =  tie_winner;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // A grant is only ever raised for an active request, so any grant is an accept.
  assign accept    = gnt0 | gnt1;
  assign accept_id = gnt1;

  // -------------------------------------------------------------------------
  // Next-state and done outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        done0     = ~id_q;
        done1     =  id_q;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, operand, result and flag registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset also aborts any in-flight operation: the FSM returns to IDLE
      // before the EXEC->DONE edge, so no done and no flag update occur.
      state    <= IDLE;
      prio     <= RR_INIT;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      nzcv_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state <= state_nxt;

      if (accept) begin
        op_q <= accept_id ? op1 : op0;
        a_q  <= accept_id ? a1  : a0;
        b_q  <= accept_id ? b1  : b0;
        s_q  <= accept_id ? s1  : s0;
        id_q <= accept_id;
        prio <= ~accept_id;
      end

      // The ALU has had the whole EXEC cycle to settle on the operand
      // registers; capture its result on the way out.
      if (state == EXEC) begin
        result_q <= alu_out;
        if (s_q) begin
          nzcv_q <= {alu_n, alu_z, alu_c, alu_v};
        end
      end
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // Lock ownership: taken by any accept with its lock bit set, released only
  // when the owner itself is accepted without it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid <= 1'b0;
      lock_id    <= 1'b0;
    end else if (accept) begin
      if (accept_lock) begin
        lock_valid <= 1'b1;
        lock_id    <= accept_id;
      end else if (lock_valid && lock_id == accept_id) begin
        lock_valid <= 1'b0;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign result    = result_q;
  assign nzcv      = nzcv_q;

  assign alu_op    = op_q;
  assign alu_in1   = a_q;
  assign alu_in2   = b_q;
  assign alu_carry = nzcv_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A small behavioural ALU sits on the
// alu_* ports (opcodes chosen by this bench: ADD=0010, ADC=0011, SUB=0100
// with C as borrow, MOV=1101). Single-requester operations come from a table
// of hand-computed vectors. Reset abort, round-robin alternation and, when
// ALU_ARB_LOCK_EN is defined, priority locking are exercised by short
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic        s0, s1, lock0, lock1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] result;
  logic [3:0]  nzcv;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1, alu_in2;
  logic        alu_carry;
  logic [31:0] alu_out;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic [32:0] alu_wide;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .s0(s0), .s1(s1), .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .nzcv(nzcv),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_carry(alu_carry),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
  );

  // Behavioural ALU on the shared-ALU ports.
  always_comb begin
    alu_wide = '0;
    alu_out  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (alu_op)
      OP_ADD, OP_ADC: begin
        alu_wide = {1'b0, alu_in1} + {1'b0, alu_in2}
                 + {32'd0, (alu_op == OP_ADC) ? alu_carry : 1'b0};
        alu_out  = alu_wide[31:0];
        alu_c    = alu_wide[32];
        alu_v    = (alu_in1[31] == alu_in2[31]) && (alu_out[31] != alu_in1[31]);
      end
      OP_SUB: begin
        alu_out = alu_in1 - alu_in2;
        alu_c   = alu_in1 < alu_in2;
        alu_v   = (alu_in1[31] != alu_in2[31]) && (alu_out[31] != alu_in1[31]);
      end
      OP_MOV:  alu_out = alu_in2;
      default: alu_out = alu_in1 ^ alu_in2;
    endcase
    alu_n = alu_out[31];
    alu_z = (alu_out == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+#1 with rst low. Returns at posedge+#1 of the IDLE
  // cycle after the operation's DONE cycle.
  task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic s, output int waited,
                       output logic [31:0] res, output logic [3:0] flags,
                       output logic carry);
    logic got;
    got    = 1'b0;
    waited = 0;
    if (id == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; s0 = s; end
    else         begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; s1 = s; end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? gnt0 : gnt1) got = 1'b1;
      else begin waited++; @(posedge clk); #1; end
    end
    check("grant_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    // Requester inputs change right after accept; the in-flight op must not care.
    if (id == 0) begin req0 = 1'b0; op0 = ~op; a0 = $urandom(); b0 = $urandom(); s0 = ~s; end
    else         begin req1 = 1'b0; op1 = ~op; a1 = $urandom(); b1 = $urandom(); s1 = ~s; end
    @(negedge clk);
    check("exec_no_done", 32'({done1, done0}), 32'd0);
    check("exec_alu_op",  32'(alu_op), 32'(op));
    check("exec_alu_in1", alu_in1, a);
    check("exec_alu_in2", alu_in2, b);
    carry = alu_carry;
    @(posedge clk);
    @(negedge clk);
    check("done_owner", 32'({done1, done0}), (id == 0) ? 32'd1 : 32'd2);
    res   = result;
    flags = nzcv;
    @(posedge clk); #1;
  endtask

  // Called at posedge+#1; returns at posedge+#1 with rst low.
  task automatic apply_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_res;
    logic [3:0]  exp_nzcv;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          waited;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        carry;
    logic        got;
    logic        who;
    logic [31:0] exp_lock [5];
    logic [1:0]  exp_g, exp_d;

    // Flags carry from one vector to the next; exp_carry is nzcv[1] before the op.
    vecs[0] = '{0, OP_ADD, 32'd5,          32'd7,          1'b1, 32'd12,         4'b0000, 1'b0};
    vecs[1] = '{0, OP_SUB, 32'd3,          32'd3,          1'b1, 32'd0,          4'b0100, 1'b0};
    vecs[2] = '{1, OP_MOV, 32'd0,          32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFF,  4'b0100, 1'b0};
    vecs[3] = '{0, OP_ADD, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'd0,          4'b0110, 1'b0};
    vecs[4] = '{1, OP_ADC, 32'd0,          32'd0,          1'b1, 32'd1,          4'b0000, 1'b1};
    vecs[5] = '{0, OP_SUB, 32'd2,          32'd5,          1'b1, 32'hFFFF_FFFD,  4'b1010, 1'b0};
    vecs[6] = '{1, OP_ADD, 32'h7FFF_FFFF,  32'd1,          1'b1, 32'h8000_0000,  4'b1001, 1'b1};
    vecs[7] = '{0, OP_MOV, 32'd0,          32'h1234_5678,  1'b1, 32'h1234_5678,  4'b0000, 1'b0};
    vecs[8] = '{1, OP_ADC, 32'h10,         32'h20,         1'b0, 32'h30,         4'b0000, 1'b0};

`ifdef ALU_ARB_LOCK_EN
    exp_lock = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
`else
    exp_lock = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
`endif

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0; s0 = 1'b0; s1 = 1'b0;

    // Grant must stay low while reset is high, even with a request present.
    @(negedge clk);
    req0 = 1'b1;
    #1;
    check("gnt_low_in_reset", 32'({gnt1, gnt0}), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("rst_result",  result, 32'd0);
    check("rst_nzcv",    32'(nzcv), 32'd0);
    check("rst_done",    32'({done1, done0}), 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);
    check("rst_alu_op",  32'(alu_op), 32'd0);
    @(posedge clk); #1;

    // Table of single-requester operations, back to back.
    for (int k = 0; k < 9; k++) begin
      issue(vecs[k].id, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].s, waited, res, flags, carry);
      check($sformatf("vec%0d_wait", k),   32'(waited), 32'd0);
      check($sformatf("vec%0d_result", k), res, vecs[k].exp_res);
      check($sformatf("vec%0d_nzcv", k),   32'(flags), 32'(vecs[k].exp_nzcv));
      check($sformatf("vec%0d_carry", k),  32'(carry), 32'(vecs[k].exp_carry));
    end

    // Reset during EXEC aborts the operation.
    apply_reset();
    req0 = 1'b1; op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7; s0 = 1'b1;
    @(negedge clk);
    check("abort_gnt", 32'({gnt1, gnt0}), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'({done1, done0}), 32'd0);
      @(posedge clk); #1;
    end
    check("abort_result", result, 32'd0);
    check("abort_nzcv",   32'(nzcv), 32'd0);
    issue(0, OP_ADD, 32'd1, 32'd2, 1'b1, waited, res, flags, carry);
    check("post_abort_wait",   32'(waited), 32'd0);
    check("post_abort_result", res, 32'd3);
    check("post_abort_nzcv",   32'(flags), 32'd0);

    // Both requesting continuously: grants alternate 0,1,0,1 every 3 cycles.
    apply_reset();
    req0 = 1'b1; op0 = OP_ADD; a0 = 32'd1; b0 = 32'd1; s0 = 1'b0;
    req1 = 1'b1; op1 = OP_ADD; a1 = 32'd2; b1 = 32'd2; s1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_g = 2'b00;
      exp_d = 2'b00;
      if (c % 3 == 0) exp_g = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      if (c % 3 == 2) exp_d = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr_gnt_c%0d", c),  32'({gnt1, gnt0}), 32'(exp_g));
      check($sformatf("rr_done_c%0d", c), 32'({done1, done0}), 32'(exp_d));
      if (c % 3 == 2)
        check($sformatf("rr_result_c%0d", c), result, ((c / 3) % 2 == 0) ? 32'd2 : 32'd4);
      @(posedge clk);
    end
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Locking: requester 0 locks for three ops, then releases.
    apply_reset();
    req0 = 1'b1; op0 = OP_ADD; a0 = 32'd1; b0 = 32'd1; s0 = 1'b0; lock0 = 1'b1;
    req1 = 1'b1; op1 = OP_ADD; a1 = 32'd2; b1 = 32'd2; s1 = 1'b0; lock1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      who = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
        @(negedge clk);
        if (gnt0 | gnt1) begin got = 1'b1; who = gnt1; end
        else @(posedge clk);
      end
      check($sformatf("lock_gnt_seen%0d", k), 32'(got), 32'd1);
      check($sformatf("lock_grant%0d", k),    32'(who), exp_lock[k]);
      @(posedge clk); #1;
      if (k == 2) lock0 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, 0, requester that holds priority after reset (0 or 1).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Ports: req0, req1  in  1 each  requester n has an operation pending.
REQ-005 Ports: op0, op1  in  4 each  ALU operation code of requester n.
REQ-006 Ports: a0, a1, b0, b1  in  32 each  first/second operand of requester n.
REQ-007 Ports: s0, s1  in  1 each  requester n's operation updates the flag register.
REQ-008 Ports: lock0, lock1  in  1 each  requester n wants to keep priority (see Configuration).
REQ-009 Ports: gnt0, gnt1  out  1 each  accept strobe; request accepted when reqN & gntN.
REQ-010 Ports: done0, done1  out  1 each  result for requester n is valid this cycle.
REQ-011 Port: result  out  32  captured ALU result.
REQ-012 Port: nzcv  out  4  flag register {N,Z,C,V}.
REQ-013 Ports: alu_op  out  4, alu_in1  out  32, alu_in2  out  32, alu_carry  out  1  drive the shared ALU.
REQ-014 Ports: alu_out  in  32, alu_n, alu_z, alu_c, alu_v  in  1 each  ALU result and flags.

Function
REQ-015 FSM states: IDLE, EXEC, DONE; IDLE->EXEC on accept, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-016 gntN combinational, high only in IDLE, at most one high; with a single requester, that requester is granted.
REQ-017 Both requests in IDLE: requester holding priority is granted.
REQ-018 On accept: op, a, b, s and requester id captured in operand registers; priority passes to the other requester.
REQ-019 alu_op/alu_in1/alu_in2 driven only from operand registers; alu_carry = nzcv[1] (current C flag).
REQ-020 EXEC->DONE edge: result <= alu_out; if captured s=1, nzcv <= {alu_n, alu_z, alu_c, alu_v}, else nzcv unchanged.
REQ-021 In DONE, exactly the done of the captured requester is high for one cycle; result holds value until next EXEC->DONE edge.
REQ-022 Latency: accept at edge t; done high in cycle t+2; earliest next accept at edge t+3 (one op per 3 cycles).
REQ-023 Requester inputs are sampled only at the accept edge; changes afterwards do not affect an in-flight operation.
REQ-024 A requester may assert a new request while its previous op is in flight; it is arbitrated on return to IDLE.
REQ-025 No gnt and no done outside IDLE and DONE respectively; no other outputs beyond those listed.

Reset
REQ-026 rst high at an edge: state IDLE, priority = RR_INIT, result = 0, nzcv = 0, operand registers = 0, lock owner cleared.
REQ-027 Reset mid-operation aborts it: no done issued, flags not updated; gnt forced low while rst high.
REQ-028 After rst falls, first accept occurs at the first edge with a request.

Configuration
REQ-029 Macro ALU_ARB_LOCK_EN selects priority locking.
REQ-030 With ALU_ARB_LOCK_EN: accept with lockN=1 makes N lock owner; the owner wins every arbitration while requesting, regardless of priority; the owner accepting with lockN=0 clears ownership and priority passes per REQ-018.
REQ-031 With lock owner set but not requesting, the other requester is granted; ownership persists.
REQ-032 Without ALU_ARB_LOCK_EN: lock0/lock1 present and ignored; pure round-robin.

Verification
REQ-033 Reset, req0 only, op=ADD(0010), a=5, b=7, s=1 -> gnt0 at t, done0 at t+2, result=12, nzcv=0000.
REQ-034 req0 and req1 held high continuously, RR_INIT=0 -> grants alternate 0,1,0,1 every 3 cycles; done matches grantee.
REQ-035 SUB a=3, b=3, s=1 then MOV b=0xFFFFFFFF, s=0 -> nzcv=0100 after first, unchanged after second, result=0xFFFFFFFF.
REQ-036 ADD a=0xFFFFFFFF, b=1, s=1, then ADC a=0, b=0 -> first sets C (nzcv=0110), alu_carry=1 during second, result=1.
REQ-037 rst pulsed during EXEC -> no done, nzcv=0000, result=0, next request accepted normally.
REQ-038 ALU_ARB_LOCK_EN defined, both requesting, req0 with lock0=1 for 3 ops then lock0=0 -> grants 0,0,0,0,1.
